memory_game_engine: RTL and testbench

Parametrised gameplay engine for the Memory Matrix game. It replaces the fixed 8-tile control/datapath pair with a single block that has N tiles, configurable miss budget, solution display time and multi-level progression. The engine requests a board from the board generator, shows it for a fixed time, then scores tile presses. It drives the LED matrix, the remaining-miss display and the win/lose flags. It sits between the board generator and the top level, which supplies the buttons, LEDs and HEX display.

---
 rtl/memory_game_engine.sv | 155 +++++++++++++++
 tb/tb_memory_game_engine.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/memory_game_engine.sv
// rtl/memory_game_engine.sv - Memory Matrix gameplay engine: board request, solution display, press scoring, level progression.
module memory_game_engine #(
  parameter int TILES          = 8,
  parameter int MAX_MISSES     = 8,
  parameter int DISPLAY_CYCLES = 100000000,
  parameter int LEVELS         = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [TILES-1:0] tile_btn,
  input  logic [TILES-1:0] board_in,
  input  logic             board_valid,
  output logic             board_req,
  output logic [TILES-1:0] board_led,
  output logic [7:0]       misses_left,
  output logic [3:0]       level,
  output logic             playing,
  output logic             win,
  output logic             lose
);

  localparam int TW = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(DISPLAY_CYCLES - 1);
  localparam logic [7:0]       MISS_LOAD  = 8'(MAX_MISSES);
  localparam logic [3:0]       LAST_LEVEL = 4'(LEVELS - 1);
  localparam logic [TILES-1:0] ONE        = TILES'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_START_WAIT, S_REQ, S_BOARD_WAIT, S_SHOW, S_PLAY,
    S_CHECK, S_LEVEL_DONE, S_WIN, S_LOSE, S_END_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [TILES-1:0] btn_q;
  logic [TILES-1:0] found_q, found_d;
  logic [TILES-1:0] solution_q, solution_d;
  logic [7:0]       misses_q, misses_d;
  logic [3:0]       level_q, level_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [TILES-1:0] rise;
  logic             single_rise;

  // Exactly one newly pressed tile counts; simultaneous rises are dropped whole.
  assign rise        = tile_btn & ~btn_q;
  assign single_rise = (rise != '0) && ((rise & (rise - ONE)) == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      btn_q      <= '0;
      found_q    <= '0;
      solution_q <= '0;
      misses_q   <= MISS_LOAD;
      level_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      btn_q      <= tile_btn;
      found_q    <= found_d;
      solution_q <= solution_d;
      misses_q   <= misses_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    found_d    = found_q;
    solution_d = solution_q;
    misses_d   = misses_q;
    level_d    = level_q;
    timer_d    = timer_q;
    board_req  = 1'b0;
    board_led  = '0;
    playing    = 1'b0;
    win        = 1'b0;
    lose       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START_WAIT;
      end
      S_START_WAIT: begin
        if (!start) state_d = S_REQ;
      end
      S_REQ: begin
        board_req = 1'b1;
        state_d   = S_BOARD_WAIT;
      end
      S_BOARD_WAIT: begin
        if (board_valid) begin
          solution_d = board_in;
          found_d    = '0;
          misses_d   = MISS_LOAD;
          timer_d    = TIMER_LOAD;
          state_d    = S_SHOW;
        end
      end
      S_SHOW: begin
        board_led = solution_q;
        if (timer_q == '0) state_d = S_PLAY;
        else               timer_d = timer_q - 1'b1;
      end
      S_PLAY: begin
        playing   = 1'b1;
        board_led = found_q;
        if (single_rise) begin
          state_d = S_CHECK;
          if ((rise & solution_q) != '0) found_d  = found_q | (rise & solution_q);
          else if (misses_q != 8'd0)     misses_d = misses_q - 8'd1;
        end
      end
      S_CHECK: begin
        playing   = 1'b1;
        board_led = found_q;
        if (misses_q == 8'd0)            state_d = S_LOSE;
        else if (found_q == solution_q)  state_d = S_LEVEL_DONE;
        else                             state_d = S_PLAY;
      end
      S_LEVEL_DONE: begin
        board_led = found_q;
        if (level_q == LAST_LEVEL) begin
          state_d = S_WIN;
        end else begin
          level_d = level_q + 4'd1;
          state_d = S_REQ;
        end
      end
      S_WIN: begin
        win       = 1'b1;
        board_led = '1;
        if (start) state_d = S_END_WAIT;
      end
      S_LOSE: begin
        lose      = 1'b1;
        board_led = solution_q;
        if (start) state_d = S_END_WAIT;
      end
      S_END_WAIT: begin
        if (!start) begin
          level_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign misses_left = misses_q;
  assign level       = level_q;

endmodule

// File: tb/tb_memory_game_engine.sv
// tb/tb_memory_game_engine.sv - directed table-driven bench for memory_game_engine (8 tiles, 3 misses, 4-cycle show, 2 levels).
module tb_memory_game_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tile_btn;
  logic [7:0] board_in;
  logic       board_valid;
  logic       board_req;
  logic [7:0] board_led;
  logic [7:0] misses_left;
  logic [3:0] level;
  logic       playing;
  logic       win;
  logic       lose;

  int n_cmp = 0;
  int n_err = 0;

  memory_game_engine #(
    .TILES(8), .MAX_MISSES(3), .DISPLAY_CYCLES(4), .LEVELS(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .tile_btn(tile_btn),
    .board_in(board_in), .board_valid(board_valid), .board_req(board_req),
    .board_led(board_led), .misses_left(misses_left), .level(level),
    .playing(playing), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [7:0]  btn;
    logic [7:0]  bin;
    logic        bv;
    logic [23:0] exp;
  } vec_t;

  vec_t tab[$];

  // Expected output bundle: {board_req, board_led, misses_left, level, playing, win, lose}
  function automatic logic [23:0] ex(logic req, logic [7:0] led, logic [7:0] ml,
                                     logic [3:0] lvl, logic pl, logic w, logic l);
    return {req, led, ml, lvl, pl, w, l};
  endfunction

  function automatic vec_t v(logic st, logic [7:0] btn, logic [7:0] bin, logic bv, logic [23:0] e);
    vec_t r;
    r.st = st; r.btn = btn; r.bin = bin; r.bv = bv; r.exp = e;
    return r;
  endfunction

  task automatic step(input logic st, input logic [7:0] btn, input logic [7:0] bin, input logic bv);
    start = st; tile_btn = btn; board_in = bin; board_valid = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [23:0] e);
    logic [23:0] act;
    act = {board_req, board_led, misses_left, level, playing, win, lose};
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: got req=%b led=%h ml=%0d lvl=%0d pl=%b w=%b l=%b, expected req=%b led=%h ml=%0d lvl=%0d pl=%b w=%b l=%b",
               name, act[23], act[22:15], act[14:7], act[6:3], act[2], act[1], act[0],
               e[23], e[22:15], e[14:7], e[6:3], e[2], e[1], e[0]);
    end
  endtask

  task automatic sc(input string name, input logic st, input logic [7:0] btn,
                    input logic [7:0] bin, input logic bv, input logic [23:0] e);
    step(st, btn, bin, bv);
    check(name, e);
  endtask

  task automatic pulse_reset(input string name);
    #2 reset = 1'b0;
    #1 check(name, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    #2 reset = 1'b1;
  endtask

  initial begin
    // Game 1: level 0 board 05 cleared, level 1 board 80 lost; double-rise ignored.
    tab.push_back(v(1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(1, 8'h00, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h05, 1, ex(0, 8'h05, 8'd3, 4'd0, 0, 0, 0)));
    for (int i = 0; i < 3; i++)
      tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h05, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h01, 8'h00, 0, ex(0, 8'h01, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h01, 8'h00, 0, ex(0, 8'h01, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h01, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h01, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h04, 8'h00, 0, ex(0, 8'h05, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h04, 8'h00, 0, ex(0, 8'h05, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(1, 8'h00, 8'd3, 4'd1, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd1, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h80, 1, ex(0, 8'h80, 8'd3, 4'd1, 0, 0, 0)));
    for (int i = 0; i < 3; i++)
      tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h80, 8'd3, 4'd1, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h02, 8'h00, 0, ex(0, 8'h00, 8'd2, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h02, 8'h00, 0, ex(0, 8'h00, 8'd2, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd2, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h03, 8'h00, 0, ex(0, 8'h00, 8'd2, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd2, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h04, 8'h00, 0, ex(0, 8'h00, 8'd1, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd1, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h08, 8'h00, 0, ex(0, 8'h00, 8'd0, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h80, 8'd0, 4'd1, 0, 0, 1)));
    tab.push_back(v(1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd0, 4'd1, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd0, 4'd0, 0, 0, 0)));
    // Game 2: repeat press of a found tile, stray board_valid, held tile 7 across SHOW, win.
    tab.push_back(v(1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd0, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(1, 8'h00, 8'd0, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd0, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h05, 1, ex(0, 8'h05, 8'd3, 4'd0, 0, 0, 0)));
    for (int i = 0; i < 3; i++)
      tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h05, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h01, 8'h00, 0, ex(0, 8'h01, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h01, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h01, 8'h00, 0, ex(0, 8'h01, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'hFF, 1, ex(0, 8'h01, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h04, 8'h00, 0, ex(0, 8'h05, 8'd3, 4'd0, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h05, 8'd3, 4'd0, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(1, 8'h00, 8'd3, 4'd1, 0, 0, 0)));
    tab.push_back(v(1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd1, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h80, 1, ex(0, 8'h80, 8'd3, 4'd1, 0, 0, 0)));
    for (int i = 0; i < 3; i++)
      tab.push_back(v(0, 8'h80, 8'h00, 0, ex(0, 8'h80, 8'd3, 4'd1, 0, 0, 0)));
    tab.push_back(v(0, 8'h80, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd1, 1, 0, 0)));
    tab.push_back(v(1, 8'h80, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h80, 8'h00, 0, ex(0, 8'h80, 8'd3, 4'd1, 1, 0, 0)));
    tab.push_back(v(0, 8'h80, 8'h00, 0, ex(0, 8'h80, 8'd3, 4'd1, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'hFF, 8'd3, 4'd1, 0, 1, 0)));
    tab.push_back(v(1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd1, 0, 0, 0)));
    tab.push_back(v(0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0)));

    reset = 1'b0; start = 1'b0; tile_btn = '0; board_in = '0; board_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    #4 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i].st, tab[i].btn, tab[i].bin, tab[i].bv);
      check($sformatf("vec%0d", i), tab[i].exp);
    end

    // Async reset during SHOW
    sc("show_sw",   1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    sc("show_req",  0, 8'h00, 8'h00, 0, ex(1, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    sc("show_bw",   0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    sc("show_led",  0, 8'h00, 8'h80, 1, ex(0, 8'h80, 8'd3, 4'd0, 0, 0, 0));
    pulse_reset("rst_in_show");
    sc("idle_after_rst", 0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));

    // Async reset during PLAY with one miss left
    sc("p_sw",  1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    sc("p_req", 0, 8'h00, 8'h00, 0, ex(1, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    step(0, 8'h00, 8'h00, 0);
    step(0, 8'h00, 8'h80, 1);
    repeat (3) step(0, 8'h00, 8'h00, 0);
    sc("p_play",  0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 1, 0, 0));
    sc("p_miss1", 0, 8'h01, 8'h00, 0, ex(0, 8'h00, 8'd2, 4'd0, 1, 0, 0));
    step(0, 8'h00, 8'h00, 0);
    sc("p_miss2", 0, 8'h02, 8'h00, 0, ex(0, 8'h00, 8'd1, 4'd0, 1, 0, 0));
    sc("p_one",   0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd1, 4'd0, 1, 0, 0));
    pulse_reset("rst_in_play");

    // board_valid in IDLE ignored, then an all-zero board completes on the first press
    sc("idle_bv",  0, 8'h00, 8'h80, 1, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    sc("z_sw",     1, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    sc("z_req",    0, 8'h00, 8'h00, 0, ex(1, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    sc("z_bw",     0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 0, 0, 0));
    step(0, 8'h00, 8'h00, 1);
    repeat (3) step(0, 8'h00, 8'h00, 0);
    sc("z_play",   0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd3, 4'd0, 1, 0, 0));
    sc("z_check",  0, 8'h08, 8'h00, 0, ex(0, 8'h00, 8'd2, 4'd0, 1, 0, 0));
    sc("z_done",   0, 8'h00, 8'h00, 0, ex(0, 8'h00, 8'd2, 4'd0, 0, 0, 0));
    sc("z_next",   0, 8'h00, 8'h00, 0, ex(1, 8'h00, 8'd2, 4'd1, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
